ex_trace_buffer: RTL and testbench
==================================

// Module: ex_trace_buffer
// PURPOSE
//   Debug trace sink for the pipelined RISC-V CPU; receives the EX-stage observation outputs the core drives.
//   An armed trigger FSM captures a bounded run of EX-stage records into a circular FIFO.
//   A valid/ready read port drains the records to a host/bench, so runs need no waveform inspection.
//   Sits beside RiscVCPU_top.
// PARAMETERS
//   ADDR_W   4   FIFO address width; depth = 2**ADDR_W records
//   CAP_LEN  8   records counted per capture run (1..65535)
// PORTS
//   CLK        in   1   clock, rising edge
//   Resetn     in   1   reset, asynchronous, active-low
//   arm        in   1   1-cycle pulse: flush FIFO, clear overflow, enter ARMED
//   trig_en    in   1   1: wait for PC match; 0: trigger on first valid record
//   trig_pc    in   32  trigger PC, compared to in_PC_EX
//   in_valid   in   1   EX stage holds a real instruction (not bubble/flush)
//   in_PC_EX   in   32  EX-stage PC
//   in_ALUout  in   32  EX-stage ALU result
//   in_Zero    in   1   ALU zero flag
//   in_Branch  in   1   branch control in EX
//   in_Jump    in   1   jump control in EX
//   in_MemWr   in   1   store control in EX
//   rd_valid   out  1   head record available
//   rd_ready   in   1   host accepts head record
//   rd_data    out  68  {pc[67:36], alu[35:4], Branch, Jump, MemWr, Zero}
//   state      out  2   IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   count      out  ADDR_W+1  records held in FIFO
//   overflow   out  1   sticky: a capture record was dropped because FIFO was full
// BEHAVIOUR
//   Reset (async on Resetn=0):
//     state=IDLE, count=0, rd_ptr=wr_ptr=0, captured=0, overflow=0, rd_valid=0, rd_data=0.
//   arm=1 (any state):
//     next edge flushes pointers/count, clears overflow and captured, state->ARMED.
//     Highest priority: a same-cycle pop and the same-cycle input record are both ignored.
//   IDLE/DONE: input ignored; FIFO retained and readable.
//   ARMED: hit = in_valid & (~trig_en | in_PC_EX==trig_pc).
//     On hit: write record this edge, captured=1, state->CAPTURE (->DONE if CAP_LEN==1).
//   CAPTURE: each in_valid writes one record and captured+=1.
//     When captured reaches CAP_LEN: state->DONE at that edge.
//   Push when full (count==2**ADDR_W and no pop this cycle):
//     record dropped, overflow<=1, captured still increments.
//   Full with simultaneous pop: push accepted, count unchanged.
//   Read side (show-ahead):
//     rd_valid = (count!=0); rd_data = head record when rd_valid, else 0.
//     Pop on rd_valid&rd_ready; legal in every state.
//   Empty with simultaneous push: rd_valid=0 that cycle; record visible next cycle (1-cycle write-to-read latency).
//   Pointers wrap modulo 2**ADDR_W; count = pushes - pops, never exceeds 2**ADDR_W.
//   Reset mid-capture: all state lost, FIFO contents treated as empty.
// TESTING
//   1. Reset, trig_en=0, arm, 8 valid records PC=0,4..28, rd_ready=0
//      -> state DONE after 8th; count=8; drain yields PCs 0..28 in order.
//   2. trig_en=1, trig_pc=0x10, arm; PCs 0,4,8,0xC,0x10..
//      -> first record PC 0x10; exactly 8 records; in_valid=0 cycles not stored.
//   3. ADDR_W=2, CAP_LEN=6, no reads
//      -> count=4, overflow=1, state DONE after 6 valid inputs; drain gives first 4 records.
//   4. Full FIFO, push with rd_ready=1 same cycle
//      -> count stays 4; popped = oldest record, new record appended at tail.
//   5. arm during CAPTURE with rd_ready=1 and in_valid=1
//      -> next cycle state ARMED, count=0, overflow=0, rd_valid=0.
//   6. Resetn low mid-CAPTURE (asynchronous, between edges)
//      -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_trace_buffer.sv
// rtl/ex_trace_buffer.sv - EX-stage trace sink: trigger FSM feeding a show-ahead circular FIFO
// Records are {pc, alu, Branch, Jump, MemWr, Zero}; arm always wins over reads and captures.
module ex_trace_buffer #(
  parameter int ADDR_W  = 4,
  parameter int CAP_LEN = 8
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic              in_valid,
  input  logic [31:0]       in_PC_EX,
  input  logic [31:0]       in_ALUout,
  input  logic              in_Zero,
  input  logic              in_Branch,
  input  logic              in_Jump,
  input  logic              in_MemWr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [67:0]       rd_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     CAP_LAST = 16'(CAP_LEN);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [15:0]         captured_q, captured_d;
  logic                overflow_q, overflow_d;
  logic [67:0]         mem_q [DEPTH];

  logic [67:0]         record;
  logic                full, hit, push_req, push, pop;

  always_comb begin
    record     = {in_PC_EX, in_ALUout, in_Branch, in_Jump, in_MemWr, in_Zero};
    full       = (count_q == FULL_CNT);
    pop        = (count_q != '0) & rd_ready & ~arm;
    hit        = in_valid & (~trig_en | (in_PC_EX == trig_pc));
    push_req   = ~arm & (((state_q == ST_ARMED) & hit) | ((state_q == ST_CAPTURE) & in_valid));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push       = push_req & (~full | pop);

    state_d    = state_q;
    captured_d = captured_q;
    overflow_d = overflow_q | (push_req & full & ~pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

    case (state_q)
      ST_ARMED: begin
        if (hit) begin
          captured_d = 16'd1;
          state_d    = (CAP_LAST == 16'd1) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          captured_d = captured_q + 16'd1;
          if (captured_q + 16'd1 == CAP_LAST) state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    if (arm) begin
      state_d    = ST_ARMED;
      captured_d = '0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      captured_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= record;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ex_trace_buffer.sv
// tb/tb_ex_trace_buffer.sv - scoreboard bench for ex_trace_buffer (default and 4-deep instances)
module tb_ex_trace_buffer;

  logic        CLK = 1'b0;
  logic        Resetn;
  logic        arm_a, arm_b, rd_ready_a, rd_ready_b;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        in_valid;
  logic [31:0] in_PC_EX, in_ALUout;
  logic        in_Zero, in_Branch, in_Jump, in_MemWr;

  logic        rd_valid_a, rd_valid_b, overflow_a, overflow_b;
  logic [67:0] rd_data_a, rd_data_b;
  logic [1:0]  state_a, state_b;
  logic [4:0]  count_a;
  logic [2:0]  count_b;

  int tests = 0;
  int fails = 0;
  logic [67:0] exp_a[$];
  logic [67:0] exp_b[$];

  always #5 CLK = ~CLK;

  ex_trace_buffer u_a (
    .CLK(CLK), .Resetn(Resetn), .arm(arm_a), .trig_en(trig_en), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_PC_EX(in_PC_EX), .in_ALUout(in_ALUout), .in_Zero(in_Zero),
    .in_Branch(in_Branch), .in_Jump(in_Jump), .in_MemWr(in_MemWr),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a),
    .state(state_a), .count(count_a), .overflow(overflow_a)
  );

  ex_trace_buffer #(.ADDR_W(2), .CAP_LEN(6)) u_b (
    .CLK(CLK), .Resetn(Resetn), .arm(arm_b), .trig_en(trig_en), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_PC_EX(in_PC_EX), .in_ALUout(in_ALUout), .in_Zero(in_Zero),
    .in_Branch(in_Branch), .in_Jump(in_Jump), .in_MemWr(in_MemWr),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b),
    .state(state_b), .count(count_b), .overflow(overflow_b)
  );

  function automatic logic [31:0] alu_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [67:0] rec(input logic [31:0] pc);
    return {pc, alu_of(pc), pc[2], pc[3], pc[4], pc[5]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid  = v;
    in_PC_EX  = pc;
    in_ALUout = alu_of(pc);
    in_Branch = pc[2];
    in_Jump   = pc[3];
    in_MemWr  = pc[4];
    in_Zero   = pc[5];
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin : mon_a
    logic [67:0] e;
    if (Resetn && rd_valid_a && rd_ready_a && !arm_a) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL pop_a: got %0h expected no record", rd_data_a);
      end else begin
        e = exp_a.pop_front();
        if (rd_data_a !== e) begin
          fails++;
          $display("FAIL pop_a: got %0h expected %0h", rd_data_a, e);
        end
      end
    end
  end

  always @(negedge CLK) begin : mon_b
    logic [67:0] e;
    if (Resetn && rd_valid_b && rd_ready_b && !arm_b) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL pop_b: got %0h expected no record", rd_data_b);
      end else begin
        e = exp_b.pop_front();
        if (rd_data_b !== e) begin
          fails++;
          $display("FAIL pop_b: got %0h expected %0h", rd_data_b, e);
        end
      end
    end
  end

  task automatic drain_a;
    rd_ready_a = 1'b1;
    for (int k = 0; k < 40 && rd_valid_a; k++) step();
    rd_ready_a = 1'b0;
    check("drain_a_empty", rd_valid_a, 1'b0);
    check("drain_a_queue", exp_a.size(), 0);
  endtask

  task automatic drain_b;
    rd_ready_b = 1'b1;
    for (int k = 0; k < 40 && rd_valid_b; k++) step();
    rd_ready_b = 1'b0;
    check("drain_b_empty", rd_valid_b, 1'b0);
    check("drain_b_queue", exp_b.size(), 0);
  endtask

  logic [31:0] t2_pc [17] = '{32'h0, 32'h4, 32'h10, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h18,
                              32'h1C, 32'h20, 32'h24, 32'h28, 32'h28, 32'h2C, 32'h30, 32'h34};
  bit          t2_v  [17] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  bit          t2_e  [17] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; arm_a = 1'b0; arm_b = 1'b0; rd_ready_a = 1'b0; rd_ready_b = 1'b0;
    trig_en = 1'b0; trig_pc = '0;
    drive(1'b0, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state_a", state_a, 2'd0);
    check("rst_count_a", count_a, 0);
    check("rst_rd_valid_a", rd_valid_a, 1'b0);
    check("rst_rd_data_a", rd_data_a, 68'h0);
    check("rst_overflow_a", overflow_a, 1'b0);
    check("rst_state_b", state_b, 2'd0);
    Resetn = 1'b1;
    step();

    // 1: free-running trigger, 8 records, held until drained
    arm_a = 1'b1; exp_a.delete(); step(); arm_a = 1'b0;
    check("t1_armed", state_a, 2'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i)); exp_a.push_back(rec(32'(4 * i))); step();
    end
    drive(1'b1, 32'h100); step();
    drive(1'b0, 32'h0);
    check("t1_done", state_a, 2'd3);
    check("t1_count", count_a, 8);
    drain_a();

    // 2: PC trigger at 0x10 with bubbles
    trig_en = 1'b1; trig_pc = 32'h10;
    arm_a = 1'b1; exp_a.delete(); step(); arm_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 5) begin
        check("t2_still_armed", state_a, 2'd1);
        check("t2_pre_count", count_a, 0);
      end
      drive(t2_v[i], t2_pc[i]);
      if (t2_e[i]) exp_a.push_back(rec(t2_pc[i]));
      step();
    end
    drive(1'b0, 32'h0);
    check("t2_done", state_a, 2'd3);
    check("t2_count", count_a, 8);
    drain_a();

    // 3: 4-deep FIFO, 6-record capture overflows
    trig_en = 1'b0;
    arm_b = 1'b1; exp_b.delete(); step(); arm_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h100 + 4 * i));
      if (i < 4) exp_b.push_back(rec(32'(32'h100 + 4 * i)));
      step();
    end
    drive(1'b0, 32'h0);
    check("t3_count", count_b, 4);
    check("t3_overflow", overflow_b, 1'b1);
    check("t3_done", state_b, 2'd3);
    drain_b();
    check("t3_overflow_sticky", overflow_b, 1'b1);

    // 4: push into a full FIFO while popping
    arm_b = 1'b1; exp_b.delete(); step(); arm_b = 1'b0;
    check("t4_overflow_cleared", overflow_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h200 + 4 * i)); exp_b.push_back(rec(32'(32'h200 + 4 * i))); step();
    end
    drive(1'b0, 32'h0);
    check("t4_full", count_b, 4);
    check("t4_capture", state_b, 2'd2);
    drive(1'b1, 32'h210); exp_b.push_back(rec(32'h210)); rd_ready_b = 1'b1;
    step();
    rd_ready_b = 1'b0; drive(1'b0, 32'h0);
    check("t4_count_same", count_b, 4);
    check("t4_no_overflow", overflow_b, 1'b0);
    check("t4_new_head", rd_data_b, rec(32'h204));

    // 5: arm mid-capture beats pop and push
    drive(1'b1, 32'h300); rd_ready_b = 1'b1; arm_b = 1'b1; exp_b.delete();
    step();
    arm_b = 1'b0; rd_ready_b = 1'b0; drive(1'b0, 32'h0);
    check("t5_armed", state_b, 2'd1);
    check("t5_count", count_b, 0);
    check("t5_overflow", overflow_b, 1'b0);
    check("t5_rd_valid", rd_valid_b, 1'b0);

    // 6: asynchronous reset between edges
    arm_a = 1'b1; exp_a.delete(); step(); arm_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h400 + 4 * i)); exp_a.push_back(rec(32'(32'h400 + 4 * i))); step();
    end
    drive(1'b0, 32'h0);
    check("t6_capture", state_a, 2'd2);
    check("t6_count", count_a, 3);
    #2;
    Resetn = 1'b0;
    #1;
    exp_a.delete(); exp_b.delete();
    check("t6_rst_state", state_a, 2'd0);
    check("t6_rst_count", count_a, 0);
    check("t6_rst_rd_valid", rd_valid_a, 1'b0);
    check("t6_rst_rd_data", rd_data_a, 68'h0);
    check("t6_rst_count_b", count_b, 0);
    step(); step();
    Resetn = 1'b1;
    step();
    check("t6_idle_after", state_a, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
